// File: rtl/clkdiv_seq_ctrl_if.sv
// Config channel into the clock-divider sequencer: valid/ready offer of ratio, mode and burst count.
// The master (register slave) drives the offer and the sequencer returns cfg_ready.
interface clkdiv_seq_ctrl_if #(
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CNT_WIDTH-1:0]   cfg_div;
  logic                   cfg_mode;
  logic [BURST_WIDTH-1:0] cfg_count;

  modport master (
    output cfg_valid, cfg_div, cfg_mode, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_mode, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/clkdiv_seq_ctrl.sv
// Divide-counter sequencer: continuous/burst runs, stop drain, ratio changes only at period boundaries.
// Latency: start at t -> cnt=0 at t+1, first tick_en at t+N; done/cfg_err are registered one-cycle pulses.
// Backpressure: cfg_ready drops while a shadow config waits for the next wrap outside IDLE.
module clkdiv_seq_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  clkdiv_seq_ctrl_if.slave     cfg,
  input  logic                 start,
  input  logic                 stop,
  output logic                 tick_en,
  output logic                 div_clk,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   cur_div_d;
  logic                   mode_q, mode_d;
  logic [BURST_WIDTH-1:0] count_q, count_d;
  logic                   pending_q, pending_d;
  logic [CNT_WIDTH-1:0]   sh_div_q, sh_div_d;
  logic                   sh_mode_q, sh_mode_d;
  logic [BURST_WIDTH-1:0] sh_count_q, sh_count_d;
  logic                   run_mode_q, run_mode_d;
  logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
  logic                   div_clk_d, done_d, cfg_err_d;
  logic                   cfg_fire, cfg_bad;

  assign cfg.cfg_ready = (state_q == IDLE) || !pending_q;
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_bad       = cfg.cfg_div < CNT_WIDTH'(2);
  assign busy          = (state_q != IDLE);
  assign tick_en       = (state_q != IDLE) && (cnt_q == cur_div - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_div_d   = cur_div;
    mode_d      = mode_q;
    count_d     = count_q;
    pending_d   = pending_q;
    sh_div_d    = sh_div_q;
    sh_mode_d   = sh_mode_q;
    sh_count_d  = sh_count_q;
    run_mode_d  = run_mode_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          if (!mode_q) begin
            state_d    = RUN;
            run_mode_d = 1'b0;
          end else if (count_q != '0) begin
            state_d     = RUN;
            run_mode_d  = 1'b1;
            remaining_d = count_q;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick_en) begin
          cnt_d = '0;
          // A stop landing on the last cycle of a period has nothing left to drain.
          if (stop || (run_mode_q && remaining_q == BURST_WIDTH'(1))) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (run_mode_q) begin
            remaining_d = remaining_q - BURST_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (stop) state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (tick_en) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Shadow config lands on the edge that starts the next period, or on entry to IDLE.
    if (pending_q && (tick_en || state_q == IDLE)) begin
      cur_div_d = sh_div_q;
      mode_d    = sh_mode_q;
      count_d   = sh_count_q;
      pending_d = 1'b0;
    end

    if (cfg_fire) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else if (state_q == IDLE) begin
        cur_div_d = cfg.cfg_div;
        mode_d    = cfg.cfg_mode;
        count_d   = cfg.cfg_count;
        pending_d = 1'b0;
      end else begin
        sh_div_d   = cfg.cfg_div;
        sh_mode_d  = cfg.cfg_mode;
        sh_count_d = cfg.cfg_count;
        pending_d  = 1'b1;
      end
    end

    div_clk_d = (state_d != IDLE) && (cnt_d < (cur_div_d >> 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_div     <= CNT_WIDTH'(DEFAULT_DIV);
      mode_q      <= 1'b0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      sh_div_q    <= '0;
      sh_mode_q   <= 1'b0;
      sh_count_q  <= '0;
      run_mode_q  <= 1'b0;
      remaining_q <= '0;
      div_clk     <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_div     <= cur_div_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      sh_div_q    <= sh_div_d;
      sh_mode_q   <= sh_mode_d;
      sh_count_q  <= sh_count_d;
      run_mode_q  <= run_mode_d;
      remaining_q <= remaining_d;
      div_clk     <= div_clk_d;
      done        <= done_d;
      cfg_err     <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Directed bench for clkdiv_seq_ctrl: inputs change and outputs are sampled 1ns after each rising edge.
module tb_clkdiv_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        tick_en;
  logic        div_clk;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [15:0] cur_div;

  int checks   = 0;
  int failures = 0;
  int ntick;
  int ndone;

  clkdiv_seq_ctrl_if #(.CNT_WIDTH(16), .BURST_WIDTH(8)) cfg_if ();

  clkdiv_seq_ctrl #(.CNT_WIDTH(16), .BURST_WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .cfg     (cfg_if.slave),
    .start   (start),
    .stop    (stop),
    .tick_en (tick_en),
    .div_clk (div_clk),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err),
    .cur_div (cur_div)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [15:0] dv, input logic md, input logic [7:0] ct);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = dv;
    cfg_if.cfg_mode  = md;
    cfg_if.cfg_count = ct;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_mode  = 1'b0;
    cfg_if.cfg_count = '0;

    // Reset state
    step();
    step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_tick", tick_en, 1'b0);
    chk1("rst_divclk", div_clk, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_cfgerr", cfg_err, 1'b0);
    chkw("rst_curdiv", cur_div, 16'd4);
    reset = 1'b0;
    step();
    chk1("post_rst_ready", cfg_if.cfg_ready, 1'b1);

    // Continuous run at the default ratio of 4
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk1("n4_busy", busy, 1'b1);
      chk1("n4_tick", tick_en, (c % 4) == 0);
      chk1("n4_divclk", div_clk, ((c - 1) % 4) < 2);
      step();
    end
    chkw("n4_curdiv", cur_div, 16'd4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk1("n4_stopping_busy", busy, 1'b1);
    step();
    chk1("n4_stopping_tick15", tick_en, 1'b0);
    step();
    chk1("n4_final_tick", tick_en, 1'b1);
    chk1("n4_final_busy", busy, 1'b1);
    step();
    chk1("n4_done", done, 1'b1);
    chk1("n4_idle_busy", busy, 1'b0);
    step();
    chk1("n4_done_once", done, 1'b0);

    // Burst of 5 ticks at N=3
    offer(16'd3, 1'b1, 8'd5);
    chk1("burst_cfg_ready", cfg_if.cfg_ready, 1'b1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chkw("burst_curdiv", cur_div, 16'd3);
    chk1("burst_cfgerr", cfg_err, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    ntick = 0;
    for (int c = 1; c <= 17; c++) begin
      if (tick_en) ntick++;
      chk1("burst_tick", tick_en, (c % 3 == 0) && (c <= 15));
      chk1("burst_busy", busy, c <= 15);
      chk1("burst_done", done, c == 16);
      chk1("burst_divclk", div_clk, ((c - 1) % 3 == 0) && (c <= 15));
      step();
    end
    chkw("burst_ntick", 16'(ntick), 16'd5);

    // Ratio change mid-run: N=8 -> 2, accepted at cnt=3
    offer(16'd8, 1'b0, 8'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    chkw("chg_curdiv8", cur_div, 16'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk1("chg_divclk_hi", div_clk, 1'b1);
      step();
    end
    chk1("chg_ready_before", cfg_if.cfg_ready, 1'b1);
    offer(16'd2, 1'b0, 8'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    for (int c = 5; c <= 12; c++) begin
      chk1("chg_ready", cfg_if.cfg_ready, c >= 9);
      chkw("chg_curdiv", cur_div, (c >= 9) ? 16'd2 : 16'd8);
      chk1("chg_tick", tick_en, (c == 8) || (c == 10) || (c == 12));
      chk1("chg_divclk", div_clk, (c <= 8) ? (c <= 4) : (c % 2 == 1));
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk1("chg_stop_tick", tick_en, 1'b1);
    step();
    chk1("chg_done", done, 1'b1);
    chk1("chg_idle", busy, 1'b0);

    // Rejected ratios 1 and 0 back to back
    offer(16'd1, 1'b1, 8'd7);
    chk1("bad_ready", cfg_if.cfg_ready, 1'b1);
    step();
    chk1("bad1_err", cfg_err, 1'b1);
    chkw("bad1_curdiv", cur_div, 16'd2);
    chk1("bad1_ready", cfg_if.cfg_ready, 1'b1);
    cfg_if.cfg_div = 16'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk1("bad0_err", cfg_err, 1'b1);
    step();
    chk1("bad_err_clear", cfg_err, 1'b0);
    chkw("bad_curdiv", cur_div, 16'd2);
    // Mode must still be continuous: a 7-tick burst would finish by cycle 15
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      if (done) ndone++;
      step();
    end
    chk1("bad_mode_kept", busy, 1'b1);
    chkw("bad_no_done", 16'(ndone), 16'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk1("bad_stop_tick", tick_en, 1'b1);
    step();
    chk1("bad_done", done, 1'b1);
    step();

    // Stop at cnt=1 of N=6
    offer(16'd6, 1'b0, 8'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    chkw("stop_curdiv", cur_div, 16'd6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk1("stop_divclk", div_clk, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      chk1("stop_busy", busy, 1'b1);
      chk1("stop_nodone", done, 1'b0);
      chk1("stop_tick", tick_en, c == 6);
      chk1("stop_divclk_run", div_clk, c <= 3);
      step();
    end
    chk1("stop_done", done, 1'b1);
    chk1("stop_idle", busy, 1'b0);
    step();
    chk1("stop_single_done", done, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk1("both_busy", busy, 1'b0);
    chk1("both_done", done, 1'b0);
    step();
    chk1("both_busy2", busy, 1'b0);
    chk1("both_done2", done, 1'b0);

    // Reset mid-burst with a pending config outstanding
    offer(16'd3, 1'b1, 8'd4);
    step();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    offer(16'd5, 1'b0, 8'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk1("mid_pending_ready", cfg_if.cfg_ready, 1'b0);
    reset = 1'b1;
    step();
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_tick", tick_en, 1'b0);
    chk1("mid_rst_divclk", div_clk, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_cfgerr", cfg_err, 1'b0);
    chkw("mid_rst_curdiv", cur_div, 16'd4);
    reset = 1'b0;
    step();
    chk1("mid_post_done", done, 1'b0);
    chk1("mid_post_ready", cfg_if.cfg_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("rerun_busy", busy, 1'b1);
    chk1("rerun_divclk", div_clk, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      chk1("rerun_tick", tick_en, c == 4);
      chkw("rerun_curdiv", cur_div, 16'd4);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
    chk1("rerun_final_tick", tick_en, 1'b1);
    step();
    chk1("rerun_done", done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
